// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, types and flag indices for the architectural
//               register file and its pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int ZERO_REG   = 31;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Data words are numbered MSB-first: bit 0 is the most significant bit.
  typedef logic [0:XLEN-1] xword_t;

  // NZCV condition flags; n occupies the MSB, matching index FLAG_N = 0.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard
// Description : Pending-write tracking for the register file. Decode claims
//               destination registers / flags, writeback clears them, and a
//               combinational stall is raised when decode consumes an operand
//               that is still in flight.
//               Build option: REGFILE_WB_BYPASS_EN - a same-cycle clearing
//               writeback hides the pending bit so the consumer issues in the
//               writeback cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_regwrite,
  input  reg_addr_t wb_write_addr,
  input  logic      wb_setflags,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  input  logic      rd_use_a,
  input  logic      rd_use_b,
  input  logic      rd_use_flags,
  input  logic      sb_claim,
  input  reg_addr_t sb_claim_addr,
  input  logic      sb_claim_flags,
  input  logic      sb_flush,
  output logic      stall
);

  localparam reg_addr_t C_ZERO_ADDR = reg_addr_t'(ZERO_REG);

  logic [NREGS-1:0] r_pending;
  logic             r_flags_pending;
  logic             w_claim_ok;
  logic             w_pend_a;
  logic             w_pend_b;
  logic             w_pend_flags;

  // A claim only takes effect when decode actually issues and no flush wins.
  assign w_claim_ok = sb_claim && !stall && !sb_flush;

  // Pending bits: clear on writeback, then set on claim so a younger claim
  // to the same register overrides the older writer's clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending       <= '0;
      r_flags_pending <= 1'b0;
    end else if (sb_flush) begin
      r_pending       <= '0;
      r_flags_pending <= 1'b0;
    end else begin
      if (wb_regwrite) begin
        r_pending[wb_write_addr] <= 1'b0;
      end
      if (w_claim_ok && (sb_claim_addr != C_ZERO_ADDR)) begin
        r_pending[sb_claim_addr] <= 1'b1;
      end
      if (wb_setflags) begin
        r_flags_pending <= 1'b0;
      end
      if (w_claim_ok && sb_claim_flags) begin
        r_flags_pending <= 1'b1;
      end
    end
  end

  // Effective pending state seen by decode this cycle; the zero register is
  // never considered in flight.
  always_comb begin
    w_pend_a     = r_pending[rd_addr_a] && (rd_addr_a != C_ZERO_ADDR);
    w_pend_b     = r_pending[rd_addr_b] && (rd_addr_b != C_ZERO_ADDR);
    w_pend_flags = r_flags_pending;
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_regwrite && (wb_write_addr == rd_addr_a)) begin
      w_pend_a = 1'b0;
    end
    if (wb_regwrite && (wb_write_addr == rd_addr_b)) begin
      w_pend_b = 1'b0;
    end
    if (wb_setflags) begin
      w_pend_flags = 1'b0;
    end
`endif
  end

  // Hold decode when any consumed operand is still awaiting its writeback.
  assign stall = (rd_use_a && w_pend_a) ||
                 (rd_use_b && w_pend_b) ||
                 (rd_use_flags && w_pend_flags);

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Architectural register file plus NZCV flags at the end of
//               the writeback path. Two combinational read ports and the
//               current flags feed decode; a pending-write scoreboard
//               produces the decode stall.
//               Build option: REGFILE_WB_BYPASS_EN - forward same-cycle
//               writeback data and flags to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_regwrite,
  input  reg_addr_t       wb_write_addr,
  input  logic [0:XLEN-1] wb_write_data,
  input  logic            wb_setflags,
  input  logic [0:3]      wb_flags,
  input  reg_addr_t       rd_addr_a,
  input  reg_addr_t       rd_addr_b,
  input  logic            rd_use_a,
  input  logic            rd_use_b,
  input  logic            rd_use_flags,
  output logic [0:XLEN-1] rd_data_a,
  output logic [0:XLEN-1] rd_data_b,
  output logic [0:3]      flags,
  input  logic            sb_claim,
  input  reg_addr_t       sb_claim_addr,
  input  logic            sb_claim_flags,
  input  logic            sb_flush,
  output logic            stall
);

  localparam reg_addr_t C_ZERO_ADDR = reg_addr_t'(ZERO_REG);

  logic [0:XLEN-1] r_regs [NREGS];
  nzcv_t           r_flags;

  // Commit writebacks; the zero register silently drops writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_flags <= '0;
    end else begin
      if (wb_regwrite && (wb_write_addr != C_ZERO_ADDR)) begin
        r_regs[wb_write_addr] <= wb_write_data;
      end
      if (wb_setflags) begin
        r_flags <= nzcv_t'(wb_flags);
      end
    end
  end

  // Read port A: stored value, optionally forwarded, forced to zero for ZERO_REG.
  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_regwrite && (wb_write_addr == rd_addr_a)) begin
      rd_data_a = wb_write_data;
    end
`endif
    if (rd_addr_a == C_ZERO_ADDR) begin
      rd_data_a = '0;
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    rd_data_b = r_regs[rd_addr_b];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_regwrite && (wb_write_addr == rd_addr_b)) begin
      rd_data_b = wb_write_data;
    end
`endif
    if (rd_addr_b == C_ZERO_ADDR) begin
      rd_data_b = '0;
    end
  end

  // Flags output: stored NZCV, optionally forwarded from a same-cycle setflags.
  always_comb begin
    flags = r_flags;
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_setflags) begin
      flags = wb_flags;
    end
`endif
  end

  scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .wb_regwrite    (wb_regwrite),
    .wb_write_addr  (wb_write_addr),
    .wb_setflags    (wb_setflags),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_use_a       (rd_use_a),
    .rd_use_b       (rd_use_b),
    .rd_use_flags   (rd_use_flags),
    .sb_claim       (sb_claim),
    .sb_claim_addr  (sb_claim_addr),
    .sb_claim_flags (sb_claim_flags),
    .sb_flush       (sb_flush),
    .stall          (stall)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed self-checking bench for regfile_scoreboard. Expected
//               values follow the REGFILE_WB_BYPASS_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      wb_regwrite;
  reg_addr_t wb_write_addr;
  xword_t    wb_write_data;
  logic      wb_setflags;
  logic [0:3] wb_flags;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  logic      rd_use_a;
  logic      rd_use_b;
  logic      rd_use_flags;
  xword_t    rd_data_a;
  xword_t    rd_data_b;
  logic [0:3] flags;
  logic      sb_claim;
  reg_addr_t sb_claim_addr;
  logic      sb_claim_flags;
  logic      sb_flush;
  logic      stall;

  int checks   = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk            (clk),
    .rst            (rst_n),
    .wb_regwrite    (wb_regwrite),
    .wb_write_addr  (wb_write_addr),
    .wb_write_data  (wb_write_data),
    .wb_setflags    (wb_setflags),
    .wb_flags       (wb_flags),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_use_a       (rd_use_a),
    .rd_use_b       (rd_use_b),
    .rd_use_flags   (rd_use_flags),
    .rd_data_a      (rd_data_a),
    .rd_data_b      (rd_data_b),
    .flags          (flags),
    .sb_claim       (sb_claim),
    .sb_claim_addr  (sb_claim_addr),
    .sb_claim_flags (sb_claim_flags),
    .sb_flush       (sb_flush),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wb_regwrite    = 1'b0;
    wb_write_addr  = '0;
    wb_write_data  = '0;
    wb_setflags    = 1'b0;
    wb_flags       = 4'b0000;
    rd_addr_a      = '0;
    rd_addr_b      = '0;
    rd_use_a       = 1'b0;
    rd_use_b       = 1'b0;
    rd_use_flags   = 1'b0;
    sb_claim       = 1'b0;
    sb_claim_addr  = '0;
    sb_claim_flags = 1'b0;
    sb_flush       = 1'b0;
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = reg_addr_t'(i);
      #1;
      checks++;
      if (rd_data_a !== 64'h0) begin
        failures++;
        $display("FAIL reset_x%0d: got %h expected 0", i, rd_data_a);
      end
    end
    checks++;
    if (flags !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", flags);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    // Commit x5 = DEAD, then pull reset mid-cycle: the clear must be immediate.
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd5;
    wb_write_data = 64'hDEAD;
    step();
    wb_regwrite = 1'b0;
    rd_addr_a   = 5'd5;
    #1;
    checks++;
    if (rd_data_a !== 64'hDEAD) begin
      failures++;
      $display("FAIL pre_reset_x5: got %h expected dead", rd_data_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== 64'h0) begin
      failures++;
      $display("FAIL async_reset_x5: got %h expected 0", rd_data_a);
    end
    step();
    rst_n = 1'b1;
    idle();
    step();
  endtask

  task automatic test_write_read();
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd3;
    wb_write_data = 64'h0123_4567_89AB_CDEF;
    step();
    idle();
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd3;
    rd_use_a  = 1'b1;
    #1;
    checks++;
    if (rd_data_a !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("FAIL read_a_x3: got %h expected 0123456789abcdef", rd_data_a);
    end
    checks++;
    if (rd_data_b !== 64'h0123_4567_89AB_CDEF) begin
      failures++;
      $display("FAIL read_b_x3: got %h expected 0123456789abcdef", rd_data_b);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL unclaimed_write_stall: got %b expected 0", stall);
    end
    idle();
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd31;
    wb_write_data = 64'hFFFF;
    step();
    idle();
    rd_addr_b = 5'd31;
    #1;
    checks++;
    if (rd_data_b !== 64'h0) begin
      failures++;
      $display("FAIL zero_reg_read: got %h expected 0", rd_data_b);
    end
  endtask

  task automatic test_stall_claim();
    idle();
    sb_claim      = 1'b1;
    sb_claim_addr = 5'd7;
    step();
    idle();
    rd_use_a  = 1'b1;
    rd_addr_a = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL claim_x7_stall: got %b expected 1", stall);
    end
    // Claim issued while stalled must be dropped.
    sb_claim      = 1'b1;
    sb_claim_addr = 5'd8;
    step();
    idle();
    rd_use_b  = 1'b1;
    rd_addr_b = 5'd8;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL stalled_claim_x8: got %b expected 0", stall);
    end
    idle();
    rd_use_a      = 1'b1;
    rd_addr_a     = 5'd7;
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd7;
    wb_write_data = 64'd42;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL wb_cycle_stall_x7: got %b expected 0", stall);
    end
    checks++;
    if (rd_data_a !== 64'd42) begin
      failures++;
      $display("FAIL wb_cycle_data_x7: got %h expected 2a", rd_data_a);
    end
`else
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL wb_cycle_stall_x7: got %b expected 1", stall);
    end
    checks++;
    if (rd_data_a !== 64'd0) begin
      failures++;
      $display("FAIL wb_cycle_data_x7: got %h expected 0", rd_data_a);
    end
`endif
    step();
    wb_regwrite = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL post_wb_stall_x7: got %b expected 0", stall);
    end
    checks++;
    if (rd_data_a !== 64'd42) begin
      failures++;
      $display("FAIL post_wb_data_x7: got %h expected 2a", rd_data_a);
    end
  endtask

  task automatic test_claim_clear_same();
    idle();
    sb_claim      = 1'b1;
    sb_claim_addr = 5'd9;
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd9;
    wb_write_data = 64'd5;
    step();
    idle();
    rd_use_a  = 1'b1;
    rd_addr_a = 5'd9;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL claim_wins_stall_x9: got %b expected 1", stall);
    end
    checks++;
    if (rd_data_a !== 64'd5) begin
      failures++;
      $display("FAIL claim_wins_data_x9: got %h expected 5", rd_data_a);
    end
    // Retire the younger writer so later scenarios start clean.
    idle();
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd9;
    wb_write_data = 64'd5;
    step();
    idle();
  endtask

  task automatic test_flags();
    idle();
    sb_claim       = 1'b1;
    sb_claim_addr  = 5'd31;
    sb_claim_flags = 1'b1;
    step();
    idle();
    rd_use_flags = 1'b1;
    rd_use_a     = 1'b1;
    rd_addr_a    = 5'd31;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL flags_claim_stall: got %b expected 1", stall);
    end
    rd_use_flags = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg_never_pending: got %b expected 0", stall);
    end
    rd_use_a     = 1'b0;
    rd_use_flags = 1'b1;
    wb_setflags  = 1'b1;
    wb_flags     = 4'b0110;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flags_wb_cycle_stall: got %b expected 0", stall);
    end
    checks++;
    if (flags !== 4'b0110) begin
      failures++;
      $display("FAIL flags_wb_cycle_value: got %b expected 0110", flags);
    end
`else
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL flags_wb_cycle_stall: got %b expected 1", stall);
    end
    checks++;
    if (flags !== 4'b0000) begin
      failures++;
      $display("FAIL flags_wb_cycle_value: got %b expected 0000", flags);
    end
`endif
    step();
    wb_setflags = 1'b0;
    wb_flags    = 4'b0000;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flags_post_wb_stall: got %b expected 0", stall);
    end
    checks++;
    if (flags !== 4'b0110) begin
      failures++;
      $display("FAIL flags_post_wb_value: got %b expected 0110", flags);
    end
  endtask

  task automatic test_flush();
    idle();
    sb_claim      = 1'b1;
    sb_claim_addr = 5'd1;
    step();
    sb_claim_addr  = 5'd2;
    sb_claim_flags = 1'b1;
    step();
    idle();
    rd_use_a     = 1'b1;
    rd_addr_a    = 5'd1;
    rd_use_b     = 1'b1;
    rd_addr_b    = 5'd2;
    rd_use_flags = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL pre_flush_stall: got %b expected 1", stall);
    end
    // Flush together with a claim of x4 that must be discarded.
    idle();
    sb_flush      = 1'b1;
    sb_claim      = 1'b1;
    sb_claim_addr = 5'd4;
    step();
    idle();
    rd_use_a     = 1'b1;
    rd_addr_a    = 5'd1;
    rd_use_b     = 1'b1;
    rd_addr_b    = 5'd2;
    rd_use_flags = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL post_flush_stall: got %b expected 0", stall);
    end
    idle();
    rd_use_a  = 1'b1;
    rd_addr_a = 5'd4;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_drops_claim_x4: got %b expected 0", stall);
    end
    idle();
    wb_regwrite   = 1'b1;
    wb_write_addr = 5'd1;
    wb_write_data = 64'd9;
    step();
    idle();
    rd_addr_a = 5'd1;
    #1;
    checks++;
    if (rd_data_a !== 64'd9) begin
      failures++;
      $display("FAIL post_flush_commit_x1: got %h expected 9", rd_data_a);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall_claim();
    test_claim_clear_same();
    test_flags();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
